// File: rtl/seq_scan_ctrl_pkg.sv
// Shared definitions for the serial pattern-scan controller.
//   state_e : controller state encoding (IDLE / SHIFT / REPORT)
//   PAT_W   : width of the target pattern and detector window
package seq_scan_ctrl_pkg;

    localparam int PAT_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        SHIFT  = 2'b01,
        REPORT = 2'b10
    } state_e;

endpackage

// File: rtl/seq_pat_det.sv
// Overlapping 3-bit pattern detector with a two-bit history.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous active-low reset
//   bit_i   : bit presented this cycle
//   vld_i   : bit_i is valid; history steps when high
//   clr_i   : clear history (new non-chained word)
//   pat_i   : target pattern, oldest bit in the MSB
//   match_o : Mealy match for the current bit
module seq_pat_det
    import seq_scan_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_i,
    input  logic             vld_i,
    input  logic             clr_i,
    input  logic [PAT_W-1:0] pat_i,
    output logic             match_o
);

    logic       h1_q, h0_q;
    logic [1:0] hcnt_q;

    always_ff @(posedge clk) begin
        if (!rst || clr_i) begin
            h1_q   <= 1'b0;
            h0_q   <= 1'b0;
            hcnt_q <= 2'd0;
        end else if (vld_i) begin
            // every presented bit enters the history, so matches overlap
            h1_q <= h0_q;
            h0_q <= bit_i;
            if (hcnt_q != 2'd2) hcnt_q <= hcnt_q + 2'd1;
        end
    end

    assign match_o = vld_i & (hcnt_q == 2'd2) & ({h1_q, h0_q, bit_i} == pat_i);

endmodule

// File: rtl/seq_scan_ctrl.sv
// Serial scan controller: accepts a W-bit word over a valid/ready
// handshake, presents it MSB first to the pattern detector, and reports
// the number of matches found in the word.
// Ports:
//   clk, rst  : clock and synchronous active-low reset
//   cfg_pat   : target pattern (latched at accept)
//   cfg_chain : 1 = detector history carries across words (latched at accept)
//   in_valid, in_data, in_ready : word handshake
//   ser_bit, ser_vld : bit stream into the detector
//   match     : detector match for the current bit
//   done      : one-cycle pulse, cnt_out is updated at its end
//   cnt_out   : match count of the last completed word
module seq_scan_ctrl
    import seq_scan_ctrl_pkg::*;
#(
    parameter int W  = 8,
    parameter int CW = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PAT_W-1:0] cfg_pat,
    input  logic             cfg_chain,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data,
    output logic             in_ready,
    output logic             ser_bit,
    output logic             ser_vld,
    output logic             match,
    output logic             done,
    output logic [CW-1:0]    cnt_out
);

    localparam int IW = (W > 1) ? $clog2(W) : 1;

    // state | meaning
    // IDLE   | ready for a word; accept latches word and configuration
    // SHIFT  | one bit per cycle into the detector, MSB first
    // REPORT | done pulse; match count moves to cnt_out

    state_e           state_q, state_d;
    logic [W-1:0]     word_q, word_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    cnt_out_q, cnt_out_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic             det_clr;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            word_q    <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            cnt_out_q <= '0;
            pat_q     <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            cnt_out_q <= cnt_out_d;
            pat_q     <= pat_d;
        end
    end

    // kept outside the FSM block so the detector's match does not feed back
    // into the process that drives its inputs
    assign ser_vld = (state_q == SHIFT);
    assign ser_bit = ser_vld & word_q[idx_q];

    always_comb begin
        state_d   = state_q;
        word_d    = word_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        cnt_out_d = cnt_out_q;
        pat_d     = pat_q;
        in_ready  = 1'b0;
        done      = 1'b0;
        det_clr   = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    word_d  = in_data;
                    pat_d   = cfg_pat;
                    det_clr = ~cfg_chain;
                    cnt_d   = '0;
                    idx_d   = IW'(W - 1);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (match) cnt_d = cnt_q + CW'(1);
                idx_d = idx_q - IW'(1);
                if (idx_q == '0) state_d = REPORT;
            end
            REPORT: begin
                done      = 1'b1;
                cnt_out_d = cnt_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign cnt_out = cnt_out_q;

    seq_pat_det u_det (
        .clk     (clk),
        .rst     (rst),
        .bit_i   (ser_bit),
        .vld_i   (ser_vld),
        .clr_i   (det_clr),
        .pat_i   (pat_q),
        .match_o (match)
    );

endmodule
